am_pwm_dac: RTL and testbench

AM_PWM_DAC -- requirements
Module: am_pwm_dac

---
 rtl/am_dac_pkg.sv | 17 +
 rtl/sd_modulator.sv | 39 +++
 rtl/am_pwm_dac.sv | 105 ++++++++++
 tb/tb_am_pwm_dac.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/am_dac_pkg.sv
// Shared constants and types for the AM 1-bit DAC: default sample and counter
// widths, and the output-mode encoding.
package am_dac_pkg;

  localparam int DEFAULT_WIDTH       = 7;
  localparam int DEFAULT_COUNT_WIDTH = 7;

  typedef enum logic {
    PWM         = 1'b0,
    SIGMA_DELTA = 1'b1
  } dac_mode_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sd_modulator.sv
// First-order sigma-delta modulator: the carry out of a WIDTH-bit phase
// accumulator is the 1-bit output, so its density equals din / 2**WIDTH.
module sd_modulator #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic             bit_out
);

  logic [WIDTH:0] acc_q;
  logic [WIDTH:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (enable) begin
      if (clear) begin
        acc_d = '0;
      end else begin
        // The previous carry is dropped before adding, leaving a fresh carry bit.
        acc_d = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, din};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign bit_out = acc_q[WIDTH];

endmodule

// File: rtl/am_pwm_dac.sv
// 1-bit DAC for AM samples: PWM or sigma-delta output, with period, duty and
// mode double-buffered so that changes only take effect at a period wrap.
module am_pwm_dac
  import am_dac_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   mode,
  input  logic [WIDTH-1:0]       duty_cycle,
  input  logic                   duty_valid,
  input  logic [COUNT_WIDTH-1:0] count_value,
  output logic                   pwm_out,
  output logic                   zero
);

  localparam int CMP_W = max_int(WIDTH, COUNT_WIDTH);

  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] active_period_q, active_period_d;
  logic [WIDTH-1:0]       shadow_duty_q, shadow_duty_d;
  logic [WIDTH-1:0]       active_duty_q, active_duty_d;
  dac_mode_t              active_mode_q, active_mode_d;
  logic                   pwm_q, pwm_d;
  logic                   zero_q, zero_d;

  dac_mode_t              mode_in;
  logic                   wrap;
  logic                   sd_clear;
  logic                   sd_bit;
  logic [CMP_W-1:0]       cnt_ext;
  logic [CMP_W-1:0]       duty_ext;

  assign mode_in  = dac_mode_t'(mode);
  assign cnt_ext  = CMP_W'(cnt_q);
  assign duty_ext = CMP_W'(active_duty_q);
  assign wrap     = enable && (cnt_q == active_period_q);
  assign sd_clear = wrap && (mode_in != active_mode_q);

  always_comb begin
    cnt_d           = cnt_q;
    active_period_d = active_period_q;
    shadow_duty_d   = shadow_duty_q;
    active_duty_d   = active_duty_q;
    active_mode_d   = active_mode_q;
    pwm_d           = pwm_q;
    zero_d          = zero_q;
    if (enable) begin
      cnt_d  = wrap ? '0 : cnt_q + COUNT_WIDTH'(1);
      zero_d = wrap;
      if (duty_valid) begin
        shadow_duty_d = duty_cycle;
      end
      // Active duty takes the shadow as it was before this cycle's capture.
      if (wrap) begin
        active_duty_d   = shadow_duty_q;
        active_period_d = count_value;
        active_mode_d   = mode_in;
      end
      if (active_mode_q == SIGMA_DELTA) begin
        pwm_d = sd_bit;
      end else begin
        pwm_d = (cnt_ext < duty_ext);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q           <= '0;
      active_period_q <= '1;
      shadow_duty_q   <= '0;
      active_duty_q   <= '0;
      active_mode_q   <= PWM;
      pwm_q           <= 1'b0;
      zero_q          <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      active_period_q <= active_period_d;
      shadow_duty_q   <= shadow_duty_d;
      active_duty_q   <= active_duty_d;
      active_mode_q   <= active_mode_d;
      pwm_q           <= pwm_d;
      zero_q          <= zero_d;
    end
  end

  sd_modulator #(
    .WIDTH(WIDTH)
  ) u_sd_modulator (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .clear  (sd_clear),
    .din    (active_duty_q),
    .bit_out(sd_bit)
  );

  assign pwm_out = pwm_q;
  assign zero    = zero_q;

endmodule

// File: tb/tb_am_pwm_dac.sv
// Bench for am_pwm_dac: per-period expectations (high count, length) are queued
// by the stimulus and checked by a monitor at each zero strobe.
module tb_am_pwm_dac;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b1;
  logic       mode = 1'b0;
  logic [6:0] duty_cycle = '0;
  logic       duty_valid = 1'b0;
  logic [6:0] count_value = 7'd9;
  logic       pwm_out;
  logic       zero;

  typedef struct {
    string name;
    int    highs;
    int    len;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  am_pwm_dac #(
    .WIDTH      (7),
    .COUNT_WIDTH(7)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .mode       (mode),
    .duty_cycle (duty_cycle),
    .duty_valid (duty_valid),
    .count_value(count_value),
    .pwm_out    (pwm_out),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: got %0d", name, act);
    end
  endtask

  task automatic push(input string name, input int highs, input int len);
    exp_t e;
    e.name  = name;
    e.highs = highs;
    e.len   = len;
    exp_q.push_back(e);
  endtask

  task automatic load(input logic [6:0] d);
    duty_cycle = d;
    duty_valid = 1'b1;
    @(posedge clk);
    #1;
    duty_valid = 1'b0;
  endtask

  task automatic wait_zero(input string name, input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk);
      #1;
      if (zero) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check({name, " zero timeout"}, 0, 1);
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    bit done = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check({name, " drain timeout"}, exp_q.size(), 0);
  endtask

  // Monitor: a period's window runs from the cycle after a zero strobe up to
  // and including the next zero cycle, matching the one-cycle pwm lag.
  initial begin
    bit   started = 1'b0;
    int   highs = 0;
    int   len = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        started = 1'b0;
        highs   = 0;
        len     = 0;
      end else begin
        if (started) begin
          highs += int'(pwm_out);
          len++;
        end
        if (zero) begin
          if (started && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.name, " highs"}, highs, e.highs);
            check({e.name, " length"}, len, e.len);
          end
          started = 1'b1;
          highs   = 0;
          len     = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones;
    int n;
    bit seen;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset pwm_out", int'(pwm_out), 0);
    check("reset zero", int'(zero), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Duty 3, period 10: first wrap loads period and duty
    load(7'd3);
    wait_zero("first wrap", 200);
    push("duty3 p1", 3, 10);
    push("duty3 p2", 3, 10);
    push("duty3 p3", 3, 10);
    wait_drain("duty3", 100);

    // Duty 0 takes effect one period later
    load(7'd0);
    push("duty0 current", 3, 10);
    push("duty0 p1", 0, 10);
    push("duty0 p2", 0, 10);
    wait_drain("duty0", 100);

    // Duty above the period saturates high
    load(7'd127);
    push("duty127 current", 0, 10);
    push("duty127 p1", 10, 10);
    push("duty127 p2", 10, 10);
    wait_drain("duty127", 100);

    // Shadow 2, then 5 presented exactly on the wrap cycle (cnt==9)
    push("wrapload current", 10, 10);
    push("wrapload shadow2", 2, 10);
    push("wrapload new5", 5, 10);
    load(7'd2);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    load(7'd5);
    wait_drain("wrapload", 100);

    // Freeze 5 cycles at cnt==3 while pwm_out is high; duty_valid ignored
    push("freeze stretch", 10, 15);
    push("freeze dv ignored", 5, 10);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    enable     = 1'b0;
    duty_cycle = 7'd1;
    duty_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("freeze pwm_out c%0d", i), int'(pwm_out), 1);
      check($sformatf("freeze zero c%0d", i), int'(zero), 0);
    end
    enable     = 1'b1;
    duty_valid = 1'b0;
    wait_drain("freeze", 100);

    // Sigma-delta, duty 32: density 32/128
    mode = 1'b1;
    load(7'd32);
    wait_zero("sd switch", 50);
    repeat (8) @(posedge clk);
    ones = 0;
    for (int i = 0; i < 128; i++) begin
      @(posedge clk);
      #1;
      ones += int'(pwm_out);
    end
    check("sd density 32/128", ones, 32);

    // Back to PWM at full duty, then reset during a zero cycle
    mode = 1'b0;
    load(7'd127);
    wait_zero("pwm return w1", 50);
    wait_zero("pwm return w2", 50);
    check("pre-reset zero", int'(zero), 1);
    check("pre-reset pwm_out", int'(pwm_out), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset pwm_out", int'(pwm_out), 0);
    check("async reset zero", int'(zero), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) check("post-reset pwm_out", int'(pwm_out), 0);
      if (zero) begin
        seen = 1'b1;
        break;
      end
    end
    check("post-reset zero seen", int'(seen), 1);
    check("post-reset first zero cycles", n, 128);

    check("scoreboard leftover", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
